// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial add sequencer: FSM state encoding
// and the bit-counter width helper.
package serial_add_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bit counter must index bits 0..w-1 and never be zero-width.
    function automatic int cnt_width(input int w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/fa_bit.sv
// Purely combinational 1-bit full adder; the shared datapath cell that the
// sequencer time-shares across all bit positions.
module fa_bit (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic s,
    output logic c
);

    assign s = x ^ y ^ z;
    assign c = (x & y) | (x & z) | (y & z);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add sequencer: one full-adder cell processes a WIDTH-bit add
// LSB first, one bit per clock, with start/busy/done handshake.
// Optional macro SERIAL_ADD_OVF_EN adds a registered signed-overflow output.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state_reg;
    state_t           state_next;
    logic             accept;
    logic             last_bit;

    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [WIDTH-1:0] sum_reg;
    logic [CW-1:0]    cnt_reg;
    logic             carry_reg;
    logic             cout_reg;

    logic             cell_s;
    logic             cell_c;

    // The single shared adder cell sees the current LSBs and running carry.
    fa_bit u_fa (
        .x (a_sh_reg[0]),
        .y (b_sh_reg[0]),
        .z (carry_reg),
        .s (cell_s),
        .c (cell_c)
    );

    assign last_bit = (cnt_reg == CW'(WIDTH - 1));

    // Next-state logic; a new request is taken only when not busy.
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_bit) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = ST_RUN;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Operand capture and per-bit datapath update.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh_reg  <= '0;
            b_sh_reg  <= '0;
            sum_reg   <= '0;
            cnt_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
        end else if (accept) begin
            a_sh_reg  <= a;
            b_sh_reg  <= b;
            carry_reg <= cin;
            cnt_reg   <= '0;
        end else if (state_reg == ST_RUN) begin
            sum_reg[cnt_reg] <= cell_s;
            carry_reg        <= cell_c;
            a_sh_reg         <= a_sh_reg >> 1;
            b_sh_reg         <= b_sh_reg >> 1;
            cnt_reg          <= cnt_reg + CW'(1);
            if (last_bit) begin
                cout_reg <= cell_c;
            end
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    logic ovf_reg;

    // Signed overflow: carry into the MSB differs from carry out of it.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_reg <= 1'b0;
        end else if (!accept && state_reg == ST_RUN && last_bit) begin
            ovf_reg <= carry_reg ^ cell_c;
        end
    end

    assign ovf = ovf_reg;
`endif

    assign busy = (state_reg == ST_RUN);
    assign done = (state_reg == ST_DONE);
    assign sum  = sum_reg;
    assign cout = cout_reg;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8) against an arithmetic
// reference model; follows SERIAL_ADD_OVF_EN when defined.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    int total = 0;
    int bad = 0;
    int cyc = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: plain unsigned arithmetic and signed-overflow rule.
    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        logic [W:0] r;
        r = ref_add(x, y, c);
        return (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    endfunction

    // Present a request for one edge (or keep start high if hold is set).
    task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input bit hold);
        a = x; b = y; cin = c; start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
    endtask

    // Count busy cycles until done is observed at a negedge, bounded.
    task automatic wait_done(output int busy_n, output bit seen);
        busy_n = 0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++;
            if ({busy, done, sum, cout} !== '0) begin
                bad++;
                $display("FAIL reset_cycle%0d busy=%b done=%b sum=%h cout=%b want all 0", i, busy, done, sum, cout);
            end else
                $display("reset cycle %0d ok", i);
        end
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++;
            if ({busy, done, sum, cout} !== '0) begin
                bad++;
                $display("FAIL idle_cycle%0d busy=%b done=%b sum=%h cout=%b want all 0", i, busy, done, sum, cout);
            end else
                $display("idle cycle %0d ok", i);
        end
    endtask

    // One full add with checks of latency, result and carry.
    task automatic test_add(input string nm, input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int    n;
        bit    seen;
        logic [W:0] exp_r;
        exp_r = ref_add(x, y, c);
        launch(x, y, c, 1'b0);
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        wait_done(n, seen);
        total++;
        if (!seen || n != W) begin
            bad++;
            $display("FAIL %s_latency seen=%0d busy_cycles=%0d want seen=1 busy_cycles=%0d", nm, seen, n, W);
        end
        total++;
        if ({cout, sum} !== exp_r) begin
            bad++;
            $display("FAIL %s_result a=%h b=%h cin=%b got cout=%b sum=%h want cout=%b sum=%h",
                     nm, x, y, c, cout, sum, exp_r[W], exp_r[W-1:0]);
        end else
            $display("%s a=%h b=%h cin=%b -> cout=%b sum=%h", nm, x, y, c, cout, sum);
`ifdef SERIAL_ADD_OVF_EN
        total++;
        if (ovf !== ref_ovf(x, y, c)) begin
            bad++;
            $display("FAIL %s_ovf got=%b want=%b", nm, ovf, ref_ovf(x, y, c));
        end
`endif
        // Result must stay stable in the idle cycle after done.
        @(negedge clk);
        total++;
        if (done !== 1'b0 || {cout, sum} !== exp_r) begin
            bad++;
            $display("FAIL %s_hold done=%b cout=%b sum=%h want done=0 cout=%b sum=%h",
                     nm, done, cout, sum, exp_r[W], exp_r[W-1:0]);
        end
    endtask

    task automatic test_directed();
        test_add("basic", 8'h3C, 8'h05, 1'b0);
        test_add("ripple", 8'hFF, 8'h00, 1'b1);
        test_add("signed_ovf", 8'h7F, 8'h01, 1'b0);
        test_add("all_ones", 8'hFF, 8'hFF, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            test_add("rand", W'($urandom), W'($urandom), 1'($urandom));
        end
    endtask

    task automatic test_busy_ignore();
        logic [W:0] exp_r;
        int         pulses;
        exp_r = ref_add(8'h5A, 8'hC3, 1'b1);
        launch(8'h5A, 8'hC3, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            start = i[0];
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        pulses = 0;
        for (int i = 0; i < 14; i++) begin
            if (done) begin
                pulses++;
                total++;
                if ({cout, sum} !== exp_r) begin
                    bad++;
                    $display("FAIL churn_result got cout=%b sum=%h want cout=%b sum=%h",
                             cout, sum, exp_r[W], exp_r[W-1:0]);
                end
            end
            @(negedge clk);
        end
        total++;
        if (pulses != 1) begin
            bad++;
            $display("FAIL churn_pulses got=%0d want=1", pulses);
        end else
            $display("churn ok sum=%h cout=%b", sum, cout);
    endtask

    task automatic test_back_to_back();
        int         n;
        bit         seen;
        int         c1, c2;
        logic [W:0] exp1, exp2;
        exp1 = ref_add(8'hA7, 8'h19, 1'b0);
        exp2 = ref_add(8'h10, 8'h20, 1'b0);
        launch(8'hA7, 8'h19, 1'b0, 1'b1);
        a = 8'h10; b = 8'h20; cin = 1'b0;
        wait_done(n, seen);
        c1 = cyc;
        total++;
        if (!seen || {cout, sum} !== exp1) begin
            bad++;
            $display("FAIL b2b_first seen=%0d cout=%b sum=%h want cout=%b sum=%h",
                     seen, cout, sum, exp1[W], exp1[W-1:0]);
        end
        @(negedge clk);
        start = 1'b0;
        wait_done(n, seen);
        c2 = cyc;
        total++;
        if (!seen || (c2 - c1) != W + 1) begin
            bad++;
            $display("FAIL b2b_spacing seen=%0d gap=%0d want gap=%0d", seen, c2 - c1, W + 1);
        end
        total++;
        if ({cout, sum} !== exp2) begin
            bad++;
            $display("FAIL b2b_second got cout=%b sum=%h want cout=%b sum=%h",
                     cout, sum, exp2[W], exp2[W-1:0]);
        end else
            $display("back-to-back gap=%0d sum=%h", c2 - c1, sum);
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int pulses;
        launch(8'hEE, 8'h33, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if ({busy, done, sum, cout} !== '0) begin
            bad++;
            $display("FAIL midrst_state busy=%b done=%b sum=%h cout=%b want all 0", busy, done, sum, cout);
        end
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (done || busy) pulses++;
            @(negedge clk);
        end
        total++;
        if (pulses != 0) begin
            bad++;
            $display("FAIL midrst_quiet activity_cycles=%0d want=0", pulses);
        end else
            $display("mid-run reset discarded add");
        test_add("after_rst", 8'h81, 8'h7E, 1'b1);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial add sequencer: time-shares a single 1-bit full-adder cell across a WIDTH-bit addition, one bit per clock, LSB first.
- Owns the carry flip-flop, bit counter, operand shift registers and start/busy/done handshake.
- Sits between a requester issuing operand pairs and the shared full-adder datapath; area-minimal alternative to a ripple array.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when ready (state IDLE or DONE)
- a  input  WIDTH  operand A; captured on accepted start
- b  input  WIDTH  operand B; captured on accepted start
- cin  input  1  carry-in; captured on accepted start
- busy  output  1  high while the add is in progress (state RUN)
- done  output  1  one-cycle pulse: sum/cout valid
- sum  output  WIDTH  result; held stable from done until next accepted start
- cout  output  1  final carry-out; held with sum

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: state=IDLE, busy=0, done=0, sum=0, cout=0, carry reg=0, bit counter=0. rst has priority over every other input, including mid-RUN; an in-flight add is discarded with no done pulse.
- FSM states:
  - IDLE: on start=1, latch a, b and cin (into the carry reg), clear counter, go to RUN.
  - RUN: each cycle, the cell computes bit i from a_sh[0], b_sh[0] and the carry reg.
    - sum bit i <= cell sum; carry reg <= cell carry; shift a_sh and b_sh right; i <= i+1.
    - When i==WIDTH-1: cout <= cell carry, go to DONE.
  - DONE: done=1 for exactly this cycle.
    - start=1 is accepted here (back-to-back): latch new operands and go to RUN.
    - Otherwise go to IDLE.
- start is ignored while busy=1; operand changes during RUN have no effect.
- Latency: start accepted at edge k -> busy=1 for cycles k+1..k+WIDTH -> done=1 in cycle k+WIDTH+1. Throughput is one add per WIDTH+1 cycles.
- sum assembly: either build sum in place by bit index or shift it in from the MSB; the visible sum must be complete and correct when done=1. Intermediate sum values during RUN are don't-care, but sum must be stable from done until the next accepted start.
- Arithmetic: unsigned modulo 2^WIDTH. {cout,sum} = a + b + cin exactly.
- Counter width: max(1, clog2(WIDTH)). WIDTH=1 gives a single RUN cycle.
- Outputs are registered; there is no combinational path from inputs to outputs.

Optional Feature:
- Macro: SERIAL_ADD_OVF_EN.
- Defined: adds output port ovf (1 bit), the two's-complement signed overflow.
  - ovf = carry into MSB XOR carry out of MSB, captured in the final RUN cycle.
  - Valid and held with sum; reset value 0.
- Undefined: no ovf port and no related logic; all other behaviour is identical.

Decomposition:
- Package serial_add_pkg holds:
  - state encoding constants: ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - a counter-width function.
- One sub-module, fa_bit: purely combinational 1-bit full adder (sum = x^y^z, carry = majority), instantiated once as the shared datapath.
- FSM, counter and registers stay in serial_add_ctrl.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, start=0 -> busy=0, done=0, sum=0, cout=0 every cycle.
- Basic add, WIDTH=8: a=8'h3C, b=8'h05, cin=0, start pulse at edge k -> busy 8 cycles, done at k+9, sum=8'h41, cout=0.
- Full carry ripple: a=8'hFF, b=8'h00, cin=1 -> sum=8'h00, cout=1. With SERIAL_ADD_OVF_EN: a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, ovf=1.
- Start while busy and operand churn: second start and changed a/b mid-RUN -> ignored; result matches the first operands; exactly one done pulse.
- Back-to-back: start held high through DONE with new a=8'h10, b=8'h20 -> second done exactly WIDTH+1 cycles after the first; sum=8'h30.
- Reset mid-operation: rst=1 at RUN cycle 4 -> next cycle IDLE, busy=0, sum=0, no done. A new start afterwards completes normally.
